serial_bit_feeder: RTL and testbench
====================================

Name: serial_bit_feeder

Overview:
- Upstream feeder for the serial pattern detector (1101 / 0110 detector). Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on dout, which drives the detector's din.
- Consecutive words are streamed gaplessly, so patterns that straddle a word boundary are presented to the detector unbroken.
- dout is updated on the rising edge of clk. The detector samples on the falling edge, which gives din a half-cycle of setup.

Parameters:
- WIDTH, 8, bits per input word (2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.
- IDLE_BIT, 0, level driven on dout when no word is being shifted.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data valid.
- in_ready  output  1  feeder can accept a word this cycle (registered).
- dout  output  1  serial bit; connects to the detector's din.
- dout_valid  output  1  dout carries a data bit (not idle fill).
- frame_start  output  1  one-cycle pulse, high while dout carries the first bit of a word.
- busy  output  1  shifter active or holding register occupied.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Outputs: dout=IDLE_BIT, dout_valid=0, frame_start=0, busy=0, in_ready=1.
  - Internal: holding register empty, state=IDLE, bit counter=0.
  - Reset takes priority over everything. A word in flight or held is discarded with no partial-word completion.
  - A handshake in a cycle where rst_n=0 is ignored.
- Handshake:
  - A word is accepted when in_valid=1 and in_ready=1 at a rising edge.
  - in_ready = holding register empty, as a registered flag.
  - in_data must be stable only at the accepting edge.
- Storage: one shift register plus one holding register. At most 2 words are resident.
- State IDLE:
  - dout=IDLE_BIT, dout_valid=0.
  - On accept, the word loads directly into the shift register. After that same edge: dout = first bit, dout_valid=1, frame_start=1, counter=WIDTH-1, state -> SHIFT.
  - Latency from the accepting edge to the first bit on dout is zero edges, i.e. the bit is visible right after the accepting edge.
- State SHIFT:
  - Each edge with counter>0: shift by one bit in the MSB_FIRST direction and decrement the counter. dout_valid=1, frame_start=0.
  - An accept while in SHIFT with the holding register empty: the word goes into the holding register, and in_ready=0 from the next cycle.
- Last-bit edge (counter=0):
  - Holding register full: load the held word into the shifter, emitting its first bit with frame_start=1. The holding register empties and in_ready=1 next cycle. This is a gapless transition.
  - Holding register empty and an accept on the same edge: the accepted word goes straight to the shifter. Also gapless, and the holding register stays empty.
  - Neither: state -> IDLE, dout=IDLE_BIT, dout_valid=0.
- Each word occupies exactly WIDTH consecutive dout_valid cycles. No bit is ever repeated or dropped.
- busy = (state==SHIFT) | holding register full.
- Width rules:
  - The counter is ceil(log2(WIDTH)) bits wide and never wraps below 0.
  - The shift register fills with IDLE_BIT behind the shifted-out bits.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SHIFT};
  - default WIDTH constant;
  - IDLE_BIT default.
- No sub-module is needed. The design is a single module with a counter and shift/hold registers, roughly 150 lines.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> dout=0, dout_valid=0, in_ready=1, busy=0, and no word is accepted.
- Single word, WIDTH=8, MSB_FIRST=1, in_data=8'hD6 -> dout=1,1,0,1,0,1,1,0 over 8 cycles with frame_start on the first bit only, then dout=0 and dout_valid=0. The downstream detector flags both 1101 and 0110.
- Back-to-back: 8'hA5, 8'h3C, 8'hFF with in_valid held high -> 24 contiguous dout_valid cycles; frame_start at cycles 0, 8 and 16; in_ready low while the holding register is full.
- Backpressure: present a third word while shifter and holding register are both full -> in_ready=0 and in_data is not consumed until the cycle after the held word's load edge.
- Reset mid-word: assert rst_n=0 after bit 3 of 8'hF0 -> the next edge gives dout=IDLE_BIT, dout_valid=0, and the held word is discarded. After release a fresh word starts from bit 7.
- MSB_FIRST=0 with 8'h0B -> dout=1,1,0,1,0,0,0,0.

Source files
------------

// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the serial bit feeder: FSM states and parameter defaults.
package serial_bit_feeder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int   DEFAULT_WIDTH    = 8;
  localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: shift register plus one holding register so that
// consecutive words stream out gaplessly, one bit per clock on dout.
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] FILL     = {WIDTH{IDLE_BIT}};

  state_e             state_r, state_s;
  logic [WIDTH-1:0]   shift_r, shift_s;
  logic [WIDTH-1:0]   hold_r, hold_s;
  logic               hold_full_r, hold_full_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               frame_start_r, frame_start_s;
  logic               in_ready_r;
  logic               dout_r;
  logic               dout_valid_r;
  logic               busy_r;
  logic               accept_s;

  // Advance by one bit, back-filling with the idle level.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return {v[WIDTH-2:0], IDLE_BIT};
    end else begin
      return {IDLE_BIT, v[WIDTH-1:1]};
    end
  endfunction

  // Outgoing bit position of a shift-register image.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      return v[WIDTH-1];
    end else begin
      return v[0];
    end
  endfunction

  // Next-state, shifter and holding-register control.
  always_comb begin
    accept_s      = in_valid & in_ready_r;
    state_s       = state_r;
    shift_s       = shift_r;
    hold_s        = hold_r;
    hold_full_s   = hold_full_r;
    cnt_s         = cnt_r;
    frame_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shift_s       = in_data;
          cnt_s         = CNT_LAST;
          frame_start_s = 1'b1;
          state_s       = SHIFT;
        end else begin
          shift_s = FILL;
          cnt_s   = CNT_ZERO;
        end
      end
      SHIFT: begin
        if (cnt_r != CNT_ZERO) begin
          shift_s = shift_once(shift_r);
          cnt_s   = cnt_r - CNT_W'(1);
          if (accept_s) begin
            hold_s      = in_data;
            hold_full_s = 1'b1;
          end else begin
            hold_s = hold_r;
          end
        end else if (hold_full_r) begin
          // Last bit out: the held word follows without a gap.
          shift_s       = hold_r;
          hold_full_s   = 1'b0;
          cnt_s         = CNT_LAST;
          frame_start_s = 1'b1;
        end else if (accept_s) begin
          shift_s       = in_data;
          cnt_s         = CNT_LAST;
          frame_start_s = 1'b1;
        end else begin
          shift_s = FILL;
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
        end
      end
      default: begin
        state_s     = IDLE;
        shift_s     = FILL;
        cnt_s       = CNT_ZERO;
        hold_full_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any resident words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      shift_r       <= FILL;
      hold_r        <= {WIDTH{1'b0}};
      hold_full_r   <= 1'b0;
      cnt_r         <= CNT_ZERO;
      frame_start_r <= 1'b0;
      in_ready_r    <= 1'b1;
      dout_r        <= IDLE_BIT;
      dout_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      shift_r       <= shift_s;
      hold_r        <= hold_s;
      hold_full_r   <= hold_full_s;
      cnt_r         <= cnt_s;
      frame_start_r <= frame_start_s;
      in_ready_r    <= ~hold_full_s;
      dout_r        <= out_bit(shift_s);
      dout_valid_r  <= (state_s == SHIFT);
      busy_r        <= (state_s == SHIFT) | hold_full_s;
    end
  end

  assign in_ready    = in_ready_r;
  assign dout        = dout_r;
  assign dout_valid  = dout_valid_r;
  assign frame_start = frame_start_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: cycle table for reset, single word and
// back-to-back streaming, plus sequences for mid-word reset and LSB-first order.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, dout, dout_valid, frame_start, busy;
  logic [7:0] l_data;
  logic       l_valid;
  logic       l_ready, l_dout, l_dv, l_fs, l_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected tuple order: {dout, dout_valid, frame_start, in_ready, busy}
  typedef struct {
    logic       rst_n;
    logic       v;
    logic [7:0] d;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid),
    .frame_start(frame_start), .busy(busy)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(l_data), .in_valid(l_valid),
    .in_ready(l_ready), .dout(l_dout), .dout_valid(l_dv),
    .frame_start(l_fs), .busy(l_busy)
  );

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic [4:0] e);
    vec_t t;
    t.rst_n = r; t.v = v; t.d = d; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [4:0] got, input logic [4:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s[%0d]: got {dout,dv,fs,rdy,busy}=%b expected %b", name, idx, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst_n = r; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] lsb_bits;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hD6;
    l_valid = 1'b0; l_data = 8'h00;

    // Reset held 3 cycles with in_valid high: nothing accepted
    add(1'b0, 1'b1, 8'hD6, 5'b00010); add(1'b0, 1'b1, 8'hD6, 5'b00010); add(1'b0, 1'b1, 8'hD6, 5'b00010);
    // Single word D6 -> 1,1,0,1,0,1,1,0
    add(1'b1, 1'b1, 8'hD6, 5'b11111);
    add(1'b1, 1'b0, 8'h00, 5'b11011); add(1'b1, 1'b0, 8'h00, 5'b01011); add(1'b1, 1'b0, 8'h00, 5'b11011);
    add(1'b1, 1'b0, 8'h00, 5'b01011); add(1'b1, 1'b0, 8'h00, 5'b11011); add(1'b1, 1'b0, 8'h00, 5'b11011);
    add(1'b1, 1'b0, 8'h00, 5'b01011);
    add(1'b1, 1'b0, 8'h00, 5'b00010);
    // Back-to-back A5, 3C, FF; FF waits while the holding register is full
    add(1'b1, 1'b1, 8'hA5, 5'b11111);
    add(1'b1, 1'b1, 8'h3C, 5'b01001);
    add(1'b1, 1'b1, 8'hFF, 5'b11001); add(1'b1, 1'b1, 8'hFF, 5'b01001); add(1'b1, 1'b1, 8'hFF, 5'b01001);
    add(1'b1, 1'b1, 8'hFF, 5'b11001); add(1'b1, 1'b1, 8'hFF, 5'b01001); add(1'b1, 1'b1, 8'hFF, 5'b11001);
    add(1'b1, 1'b1, 8'hFF, 5'b01111);
    add(1'b1, 1'b1, 8'hFF, 5'b01001);
    add(1'b1, 1'b0, 8'h00, 5'b11001); add(1'b1, 1'b0, 8'h00, 5'b11001); add(1'b1, 1'b0, 8'h00, 5'b11001);
    add(1'b1, 1'b0, 8'h00, 5'b11001); add(1'b1, 1'b0, 8'h00, 5'b01001); add(1'b1, 1'b0, 8'h00, 5'b01001);
    add(1'b1, 1'b0, 8'h00, 5'b11111);
    for (int i = 0; i < 7; i++) add(1'b1, 1'b0, 8'h00, 5'b11011);
    add(1'b1, 1'b0, 8'h00, 5'b00010);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].v, tbl[i].d);
      check("table", i, {dout, dout_valid, frame_start, in_ready, busy}, tbl[i].exp);
    end

    // Reset after bit 3 of F0 with 5A held: both discarded
    step(1'b1, 1'b1, 8'hF0); check("rst_mid", 0, {dout, dout_valid, frame_start, in_ready, busy}, 5'b11111);
    step(1'b1, 1'b1, 8'h5A); check("rst_mid", 1, {dout, dout_valid, frame_start, in_ready, busy}, 5'b11001);
    step(1'b1, 1'b0, 8'h00); check("rst_mid", 2, {dout, dout_valid, frame_start, in_ready, busy}, 5'b11001);
    step(1'b1, 1'b0, 8'h00); check("rst_mid", 3, {dout, dout_valid, frame_start, in_ready, busy}, 5'b11001);
    step(1'b1, 1'b0, 8'h00); check("rst_mid", 4, {dout, dout_valid, frame_start, in_ready, busy}, 5'b01001);
    step(1'b0, 1'b1, 8'h33); check("rst_mid", 5, {dout, dout_valid, frame_start, in_ready, busy}, 5'b00010);
    step(1'b1, 1'b0, 8'h00); check("rst_mid", 6, {dout, dout_valid, frame_start, in_ready, busy}, 5'b00010);
    step(1'b1, 1'b1, 8'h81); check("fresh", 0, {dout, dout_valid, frame_start, in_ready, busy}, 5'b11111);
    for (int i = 1; i < 7; i++) begin
      step(1'b1, 1'b0, 8'h00); check("fresh", i, {dout, dout_valid, frame_start, in_ready, busy}, 5'b01011);
    end
    step(1'b1, 1'b0, 8'h00); check("fresh", 7, {dout, dout_valid, frame_start, in_ready, busy}, 5'b11011);
    step(1'b1, 1'b0, 8'h00); check("fresh", 8, {dout, dout_valid, frame_start, in_ready, busy}, 5'b00010);

    // LSB-first: 0B -> 1,1,0,1,0,0,0,0
    lsb_bits = 8'b1101_0000;
    l_valid = 1'b1; l_data = 8'h0B;
    @(posedge clk); #1;
    l_valid = 1'b0; l_data = 8'h00;
    check("lsb", 0, {l_dout, l_dv, l_fs, l_ready, l_busy}, 5'b11111);
    for (int i = 6; i >= 0; i--) begin
      @(posedge clk); #1;
      check("lsb", 7 - i, {l_dout, l_dv, l_fs, l_ready, l_busy}, {lsb_bits[i], 4'b1011});
    end
    @(posedge clk); #1;
    check("lsb", 8, {l_dout, l_dv, l_fs, l_ready, l_busy}, 5'b00010);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
